// File: rtl/ibex_zkn_aes_sub_unit.sv
// Zkn AES byte-substitution unit: SubWord, aes32esi and aes32esmi around one shared forward S-box.
// Define IBEX_ZKN_AES_B2B_EN to accept a new request in the same cycle as the output handshake.
module ibex_zkn_aes_sub_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [1:0]  op_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        kill_i,
    output logic [7:0]  sbox_x_o,
    input  logic [7:0]  sbox_sx_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic        illegal_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_SUBWORD = 2'd0;
    localparam logic [1:0] OP_ESMI    = 2'd2;
    localparam logic [1:0] OP_RSVD    = 2'd3;

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [1:0]  op_reg, op_next;
    logic [1:0]  bs_reg, bs_next;
    logic [31:0] rs1_reg, rs1_next;
    logic [31:0] rs2_reg, rs2_next;
    logic [31:0] result_reg, result_next;

    logic        is_idle, is_run, is_done;
    logic        handshake;
    logic        accept;
    logic [7:0]  rs2_bytes [4];
    logic [31:0] sub_word;
    logic [7:0]  sx, sx2;
    logic [31:0] mix_word;
    logic [31:0] rot_word;

    assign is_idle   = (state_reg == IDLE);
    assign is_run    = (state_reg == RUN);
    assign is_done   = (state_reg == DONE);
    assign handshake = is_done & out_ready_i;

`ifdef IBEX_ZKN_AES_B2B_EN
    assign in_ready_o = is_idle | handshake;
`else
    assign in_ready_o = is_idle;
`endif

    // The reserved opcode is reported but never enters RUN.
    assign accept    = in_valid_i & in_ready_o & (op_i != OP_RSVD);
    assign illegal_o = in_valid_i & in_ready_o & (op_i == OP_RSVD);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
            assign rs2_bytes[gi]      = rs2_reg[8*gi +: 8];
            assign sub_word[8*gi +: 8] = (idx_reg == 2'(gi)) ? sbox_sx_i
                                                             : result_reg[8*gi +: 8];
        end
    endgenerate

    assign sbox_x_o = is_run ? rs2_bytes[idx_reg] : 8'h00;

    assign sx       = sbox_sx_i;
    assign sx2      = {sx[6:0], 1'b0} ^ (sx[7] ? 8'h1B : 8'h00);
    assign mix_word = (op_reg == OP_ESMI) ? {sx2 ^ sx, sx, sx, sx2} : {24'h0, sx};

    always_comb begin
        rot_word = mix_word;
        case (bs_reg)
            2'd1:    rot_word = {mix_word[23:0], mix_word[31:24]};
            2'd2:    rot_word = {mix_word[15:0], mix_word[31:16]};
            2'd3:    rot_word = {mix_word[7:0],  mix_word[31:8]};
            default: rot_word = mix_word;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        op_next     = op_reg;
        bs_next     = bs_reg;
        rs1_next    = rs1_reg;
        rs2_next    = rs2_reg;
        result_next = result_reg;

        if (kill_i) begin
            state_next = IDLE;
            idx_next   = 2'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (handshake) begin
                        state_next = IDLE;
                    end
                    if (accept) begin
                        state_next  = RUN;
                        op_next     = op_i;
                        bs_next     = bs_i;
                        rs1_next    = rs1_i;
                        rs2_next    = rs2_i;
                        result_next = 32'h0;
                        idx_next    = (op_i == OP_SUBWORD) ? 2'd0 : bs_i;
                    end
                end
                RUN: begin
                    if (op_reg == OP_SUBWORD) begin
                        result_next = sub_word;
                        idx_next    = idx_reg + 2'd1;
                        if (idx_reg == 2'd3) begin
                            state_next = DONE;
                        end
                    end else begin
                        result_next = rs1_reg ^ rot_word;
                        idx_next    = 2'd0;
                        state_next  = DONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= IDLE;
            idx_reg    <= 2'd0;
            op_reg     <= 2'd0;
            bs_reg     <= 2'd0;
            rs1_reg    <= 32'h0;
            rs2_reg    <= 32'h0;
            result_reg <= 32'h0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            op_reg     <= op_next;
            bs_reg     <= bs_next;
            rs1_reg    <= rs1_next;
            rs2_reg    <= rs2_next;
            result_reg <= result_next;
        end
    end

    assign out_valid_o = is_done;
    assign result_o    = result_reg;

endmodule

// File: tb/tb_ibex_zkn_aes_sub_unit.sv
// Scoreboard bench for ibex_zkn_aes_sub_unit with a behavioural AES S-box in the loop.
module tb_ibex_zkn_aes_sub_unit;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef IBEX_ZKN_AES_B2B_EN
    localparam int B2B_GAP = 2;
`else
    localparam int B2B_GAP = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        kill;
    logic [7:0]  sbox_x;
    logic [7:0]  sbox_sx;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   done_cyc_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   head_seen = 1'b0;

    ibex_zkn_aes_sub_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .bs_i        (bs),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .kill_i      (kill),
        .sbox_x_o    (sbox_x),
        .sbox_sx_i   (sbox_sx),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .illegal_o   (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] sbox(input logic [7:0] v);
        return SBOX[2047 - 8*int'(v) -: 8];
    endfunction

    assign sbox_sx = sbox(sbox_x);

    function automatic logic [31:0] model(input logic [1:0] o, input logic [1:0] b,
                                          input logic [31:0] r1, input logic [31:0] r2);
        logic [7:0]  x, x2;
        logic [31:0] m, r;
        if (o == 2'd0) begin
            for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox(r2[8*k +: 8]);
            return r;
        end
        x  = sbox(r2[8*b +: 8]);
        x2 = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        m  = (o == 2'd2) ? {x2 ^ x, x, x, x2} : {24'h0, x};
        r  = (b == 2'd0) ? m : ((m << (8*int'(b))) | (m >> (32 - 8*int'(b))));
        return r1 ^ r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Monitor: latency on the first valid cycle of each result, value at the handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                if (!head_seen) check("unexpected_valid", {31'b0, out_valid}, 32'd0);
                head_seen = !out_ready;
            end else begin
                if (!head_seen) begin
                    check("latency", 32'(cyc - sb_q[0].acc_cyc), 32'(sb_q[0].lat));
                    done_cyc_q.push_back(cyc);
                    head_seen = 1'b1;
                end
                if (out_ready) begin
                    check("result", result, sb_q[0].res);
                    $display("txn done: result=0x%08h expected=0x%08h cycle=%0d",
                             result, sb_q[0].res, cyc);
                    void'(sb_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    task automatic do_op(input logic [1:0] o, input logic [1:0] b,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] exp_res);
        bit got = 1'b0;
        op       = o;
        bs       = b;
        rs1      = r1;
        rs2      = r2;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            check("accept_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            sb_q.push_back('{exp_res, cyc, (o == 2'd0) ? 5 : 2});
            $display("txn issue: op=%0d bs=%0d rs1=0x%08h rs2=0x%08h cycle=%0d", o, b, r1, r2, cyc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(negedge clk);
        check("drain", 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r1, r2, w;
        logic [1:0]  o, b;

        rst       = 1'b1;
        in_valid  = 1'b1;
        op        = 2'd0;
        bs        = 2'd0;
        rs1       = 32'hDEADBEEF;
        rs2       = 32'h12345678;
        kill      = 1'b0;
        out_ready = 1'b1;

        // Reset held for two edges with a pending request.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    result,             32'h0);
        check("rst_sbox_x",    {24'b0, sbox_x},    32'h0);
        check("rst_illegal",   {31'b0, illegal},   32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // SubWord with the S-box input sequence observed per RUN cycle.
        do_op(2'd0, 2'd0, 32'h0, 32'h00010253, 32'h637C77ED);
        w = 32'h00010253;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("sbox_x_seq", {24'b0, sbox_x}, {24'b0, w[8*k +: 8]});
        end
        wait_drain();

        do_op(2'd1, 2'd1, 32'h0, 32'h0, 32'h00006300);
        wait_drain();
        do_op(2'd1, 2'd0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFF9C);
        wait_drain();
        do_op(2'd2, 2'd0, 32'h0, 32'h0, 32'hA56363C6);
        wait_drain();
        do_op(2'd2, 2'd1, 32'h0, 32'h0, 32'h6363C6A5);
        wait_drain();

        // Backpressure: result held for three cycles in DONE.
        out_ready = 1'b0;
        do_op(2'd1, 2'd2, 32'h0F0F0F0F, 32'h00AA0000, 32'h0FA30F0F);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid",    {31'b0, out_valid}, 32'd1);
            check("bp_result",   result,             32'h0FA30F0F);
            check("bp_in_ready", {31'b0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_drain();

        // Kill in the second RUN cycle of a SubWord.
        op       = 2'd0;
        rs2      = 32'hA1B2C3D4;
        in_valid = 1'b1;
        @(negedge clk);
        check("kill_accept", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        check("kill_run2_sbox", {24'b0, sbox_x}, 32'h000000C3);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        check("kill_idle",      {31'b0, in_ready},  32'd1);
        check("kill_no_valid",  {31'b0, out_valid}, 32'd0);
        check("kill_sbox_zero", {24'b0, sbox_x},    32'h0);
        repeat (6) @(posedge clk);
        #1;
        r2 = $urandom;
        do_op(2'd0, 2'd0, 32'h0, r2, model(2'd0, 2'd0, 32'h0, r2));
        wait_drain();

        // Reserved opcode.
        op       = 2'd3;
        in_valid = 1'b1;
        @(negedge clk);
        check("illegal_pulse",  {31'b0, illegal},  32'd1);
        check("illegal_ready",  {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 2'd0;
        @(negedge clk);
        check("illegal_clear",  {31'b0, illegal},   32'd0);
        check("illegal_idle",   {31'b0, in_ready},  32'd1);
        check("illegal_no_run", {24'b0, sbox_x},    32'h0);
        @(posedge clk);
        #1;

        // Random mix of operations issued back to back.
        for (int n = 0; n < 10; n++) begin
            o  = 2'($urandom_range(0, 2));
            b  = 2'($urandom_range(0, 3));
            r1 = $urandom;
            r2 = $urandom;
            do_op(o, b, r1, r2, model(o, b, r1, r2));
        end
        wait_drain();

        // Back-to-back AES32 throughput.
        done_cyc_q.delete();
        do_op(2'd1, 2'd3, 32'h01234567, 32'h89ABCDEF, model(2'd1, 2'd3, 32'h01234567, 32'h89ABCDEF));
        do_op(2'd1, 2'd0, 32'h76543210, 32'hFEDCBA98, model(2'd1, 2'd0, 32'h76543210, 32'hFEDCBA98));
        wait_drain();
        check("b2b_count", 32'(done_cyc_q.size()), 32'd2);
        if (done_cyc_q.size() == 2)
            check("b2b_gap", 32'(done_cyc_q[1] - done_cyc_q[0]), 32'(B2B_GAP));

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_zkn_aes_sub_unit.md
Name: ibex_zkn_aes_sub_unit

Overview:
- Multi-cycle AES byte-substitution datapath for the Zkn extension, directly downstream of the AES forward S-box.
- Drives the S-box input byte and consumes its substituted output, one byte per cycle.
- Supports three operations: SubWord (4 bytes through one shared S-box), aes32esi and aes32esmi.
- Sits between the ID/EX operand mux and the ALU result mux; uses a valid/ready handshake on both sides.

Parameters:
- None. Datapath width is fixed at 32 bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- in_valid_i  in  1  operation request
- in_ready_o  out  1  unit can accept a request
- op_i  in  2  operation: 0=SUBWORD, 1=AES32ESI, 2=AES32ESMI, 3=reserved
- bs_i  in  2  byte select for the AES32 operations
- rs1_i  in  32  XOR operand (AES32 operations)
- rs2_i  in  32  source word
- kill_i  in  1  flush: abandon the current operation
- sbox_x_o  out  8  byte to the S-box
- sbox_sx_i  in  8  substituted byte from the S-box; combinational, same cycle
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts the result
- result_o  out  32  result word
- illegal_o  out  1  pulse, 1 cycle: op_i=3 was presented

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset (rst_i=1 at a clock edge) goes to IDLE with:
  - idx=0, result register=0, out_valid_o=0, illegal_o=0, sbox_x_o=0
  - in_ready_o=1 (it is the combinational decode of IDLE)
- in_ready_o=1 only in IDLE.
- Accept condition: in_valid_i & in_ready_o.
  - On accept, capture op_i, bs_i, rs1_i, rs2_i; clear the result register; go to RUN.
  - SUBWORD: idx starts at 0.
  - AES32: idx is loaded with bs_i.
- op_i=3 when in_valid_i & IDLE:
  - Not accepted; stay in IDLE.
  - illegal_o=1 for that cycle.
- RUN, per cycle:
  - sbox_x_o = rs2 byte[idx], i.e. rs2[8*idx+7 : 8*idx].
  - sbox_sx_i is used in the same cycle.
  - sbox_x_o = 0 in every state other than RUN.
- SUBWORD:
  - Each RUN cycle writes sbox_sx_i into result byte[idx], then idx increments.
  - After idx=3, go to DONE: 4 RUN cycles.
  - Result: byte k = S(rs2 byte k).
- AES32ESI:
  - One RUN cycle. x = sbox_sx_i; m = {24'h0, x}.
  - result = rs1 ^ rotl32(m, 8*bs). Go to DONE.
- AES32ESMI:
  - One RUN cycle. x = sbox_sx_i; x2 = xtime(x), where xtime(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1B : 8'h00).
  - m = {x2^x, x, x, x2} (bits [31:24] down to [7:0]).
  - result = rs1 ^ rotl32(m, 8*bs). Go to DONE.
- Latency (accept edge to first out_valid_o=1 cycle): SUBWORD 5 cycles, AES32 2 cycles.
- DONE:
  - out_valid_o=1; result_o holds its value until the handshake.
  - On out_valid_o & out_ready_i, go to IDLE.
  - result_o is undefined-don't-care only when out_valid_o=0; the implementation holds the last value.
- kill_i (any state): next state IDLE, idx=0, out_valid_o=0 next cycle; no handshake completes.
  - kill_i overrides a simultaneous accept or out_ready_i.
- rst_i overrides kill_i and all other inputs. Reset in mid-RUN discards partial bytes.
- Inputs are ignored outside the accept cycle; operands are registered.

Optional Feature:
- Macro: IBEX_ZKN_AES_B2B_EN
- Defined:
  - in_ready_o = IDLE | (DONE & out_ready_i).
  - A new request may be accepted in the same cycle as the output handshake, going directly DONE→RUN.
  - Back-to-back AES32 throughput: 1 op per 2 cycles.
- Undefined:
  - in_ready_o = IDLE only; DONE→IDLE costs 1 cycle.
  - AES32 throughput: 1 op per 3 cycles.

Test Plan:
- Reset: rst_i=1 for 2 cycles with in_valid_i=1 → in_ready_o=1, out_valid_o=0, result_o=0, sbox_x_o=0; no accept during reset.
- SUBWORD, rs2=0x00010253, out_ready_i=1 → sbox_x_o sequence 0x53, 0x02, 0x01, 0x00; result_o=0x637C77ED, out_valid_o exactly 5 cycles after accept.
- AES32ESI, rs1=0, rs2=0, bs=1 → result_o=0x00006300. Then rs1=0xFFFFFFFF, bs=0 → result_o=0xFFFFFF9C. Each at latency 2.
- AES32ESMI, rs1=0, rs2=0: bs=0 → result_o=0xA56363C6; bs=1 → result_o=0x6363C6A5.
- Backpressure and kill:
  - out_ready_i=0 for 3 cycles in DONE → result_o and out_valid_o stable; in_ready_o=0 (both builds).
  - kill_i in the 2nd RUN cycle of SUBWORD → IDLE next cycle, out_valid_o never asserted, next op correct.
- op_i=3 with in_valid_i=1 → illegal_o pulses 1 cycle, state stays IDLE. With IBEX_ZKN_AES_B2B_EN, two back-to-back AES32ESI requests complete 2 cycles apart.
